// File: rtl/spi_frame_sequencer.sv
// rtl/spi_frame_sequencer.sv - SPI card reader that finds a frame header and splits the payload into video and audio bytes
`timescale 1ns/1ps
module spi_frame_sequencer #(
    parameter int unsigned SPI_DIV     = 20,
    parameter int unsigned VIDEO_BYTES = 4800,
    parameter int unsigned AUDIO_BYTES = 735,
    parameter logic [7:0]  HDR_BYTE    = 8'hFF,
    parameter int unsigned HDR_TIMEOUT = 65535
) (
    input  logic       CLK_40,
    input  logic       reset,
    input  logic       init,
    input  logic       stop,
    input  logic       MISO,
    input  logic       video_ready,
    input  logic       audio_ready,
    output logic       SPI_clk,
    output logic       MOSI,
    output logic       chip_select,
    output logic [7:0] data,
    output logic       write_video,
    output logic       write_audio,
    output logic       frame_done,
    output logic       hdr_timeout,
    output logic       busy
);

    localparam int          DW        = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SPI_DIV - 1);
    localparam logic [15:0] VID_LAST  = 16'(VIDEO_BYTES - 1);
    localparam logic [15:0] AUD_LAST  = 16'(AUDIO_BYTES - 1);
    localparam logic [15:0] HDR_LIMIT = 16'(HDR_TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT_HDR, VIDEO, AUDIO} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          spi_clk_q, spi_clk_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [15:0]   hdr_cnt_q, hdr_cnt_d;
    logic [15:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]    data_q, data_d;
    logic          write_video_q, write_video_d;
    logic          write_audio_q, write_audio_d;
    logic          frame_done_q, frame_done_d;
    logic          hdr_timeout_q, hdr_timeout_d;
    logic          pending_q, pending_d;

    logic rise, fall, byte_done, do_write, ready;

    // Next-state: SPI clock divider, bit shifting, header search and byte hand-off
    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        spi_clk_d     = spi_clk_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        hdr_cnt_d     = hdr_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        data_d        = data_q;
        write_video_d = 1'b0;
        write_audio_d = 1'b0;
        frame_done_d  = 1'b0;
        hdr_timeout_d = hdr_timeout_q;
        pending_d     = pending_q;
        rise          = 1'b0;
        fall          = 1'b0;
        byte_done     = 1'b0;
        do_write      = 1'b0;
        ready         = (state_q == VIDEO) ? video_ready : audio_ready;

        // a completed byte waiting for its buffer parks the clock low
        if (state_q != IDLE && !(pending_q && !spi_clk_q)) begin
            if (div_q == DIV_LAST) begin
                div_d     = '0;
                spi_clk_d = ~spi_clk_q;
                rise      = ~spi_clk_q;
                fall      = spi_clk_q;
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        if (rise) shift_d = {shift_q[6:0], MISO};

        case (state_q)
            IDLE: begin
                if (init && !stop) begin
                    state_d       = WAIT_HDR;
                    hdr_timeout_d = 1'b0;
                    shift_d       = '0;
                    hdr_cnt_d     = '0;
                    bit_cnt_d     = '0;
                    byte_cnt_d    = '0;
                    pending_d     = 1'b0;
                end
            end
            WAIT_HDR: begin
                // timeout is taken the cycle after the last allowed bit so that edge stays visible
                if (hdr_cnt_q == HDR_LIMIT) begin
                    state_d       = IDLE;
                    hdr_timeout_d = 1'b1;
                end else if (rise) begin
                    hdr_cnt_d = hdr_cnt_q + 16'd1;
                    if (shift_d == HDR_BYTE) begin
                        state_d    = VIDEO;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                    end
                end else if (fall && stop) begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (rise) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        data_d    = shift_d;
                        byte_done = 1'b1;
                    end
                end
                if (byte_done || pending_q) begin
                    if (ready) begin
                        do_write  = 1'b1;
                        pending_d = 1'b0;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
                if (do_write) begin
                    byte_cnt_d = byte_cnt_q + 16'd1;
                    if (state_q == VIDEO) begin
                        write_video_d = 1'b1;
                        if (byte_cnt_q == VID_LAST) begin
                            state_d    = AUDIO;
                            byte_cnt_d = '0;
                        end
                    end else begin
                        write_audio_d = 1'b1;
                        if (byte_cnt_q == AUD_LAST) begin
                            frame_done_d = 1'b1;
                            state_d      = WAIT_HDR;
                            byte_cnt_d   = '0;
                            hdr_cnt_d    = '0;
                            shift_d      = '0;
                        end
                    end
                    if (stop) state_d = IDLE;
                end
            end
        endcase

        if (state_d == IDLE) begin
            spi_clk_d = 1'b0;
            div_d     = '0;
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            div_q         <= '0;
            spi_clk_q     <= 1'b0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            hdr_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            data_q        <= '0;
            write_video_q <= 1'b0;
            write_audio_q <= 1'b0;
            frame_done_q  <= 1'b0;
            hdr_timeout_q <= 1'b0;
            pending_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            spi_clk_q     <= spi_clk_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            hdr_cnt_q     <= hdr_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            data_q        <= data_d;
            write_video_q <= write_video_d;
            write_audio_q <= write_audio_d;
            frame_done_q  <= frame_done_d;
            hdr_timeout_q <= hdr_timeout_d;
            pending_q     <= pending_d;
        end
    end

    assign SPI_clk     = spi_clk_q;
    assign MOSI        = 1'b1;
    assign chip_select = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign data        = data_q;
    assign write_video = write_video_q;
    assign write_audio = write_audio_q;
    assign frame_done  = frame_done_q;
    assign hdr_timeout = hdr_timeout_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// tb/tb_spi_frame_sequencer.sv - directed bench for spi_frame_sequencer
`timescale 1ns/1ps
module tb_spi_frame_sequencer;

    logic       CLK_40 = 1'b0;
    logic       reset = 1'b1;
    logic       init = 1'b0;
    logic       stop = 1'b0;
    logic       MISO = 1'b0;
    logic       video_ready = 1'b1;
    logic       audio_ready = 1'b1;
    logic       SPI_clk, MOSI, chip_select, write_video, write_audio, frame_done, hdr_timeout, busy;
    logic [7:0] data;

    int n_checks = 0;
    int n_err = 0;
    int n_frame = 0;
    int n_both = 0;
    int n_rise = 0;
    logic [7:0] vid[$];
    logic [7:0] aud[$];
    logic [7:0] stream[$];
    logic [7:0] expv[$];
    logic [7:0] expa[$];
    bit bits[$];

    spi_frame_sequencer #(
        .SPI_DIV(2), .VIDEO_BYTES(4), .AUDIO_BYTES(2), .HDR_BYTE(8'hFF), .HDR_TIMEOUT(100)
    ) dut (
        .CLK_40(CLK_40), .reset(reset), .init(init), .stop(stop), .MISO(MISO),
        .video_ready(video_ready), .audio_ready(audio_ready), .SPI_clk(SPI_clk),
        .MOSI(MOSI), .chip_select(chip_select), .data(data), .write_video(write_video),
        .write_audio(write_audio), .frame_done(frame_done), .hdr_timeout(hdr_timeout), .busy(busy)
    );

    always #5 CLK_40 = ~CLK_40;

    // card model: next bit presented after each falling SPI clock edge
    initial forever begin
        @(negedge SPI_clk);
        MISO = (bits.size() > 0) ? bits.pop_front() : 1'b0;
    end

    always @(posedge SPI_clk) n_rise++;

    always @(negedge CLK_40) begin
        if (write_video) vid.push_back(data);
        if (write_audio) aud.push_back(data);
        if (frame_done) n_frame++;
        if (write_video && write_audio) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int pre_zero);
        bits.delete();
        repeat (pre_zero) bits.push_back(1'b0);
        foreach (stream[i]) for (int k = 7; k >= 0; k--) bits.push_back(stream[i][k]);
        MISO = bits.pop_front();
    endtask

    task automatic clear_mon();
        @(posedge CLK_40);
        vid.delete();
        aud.delete();
        n_frame = 0;
        n_both = 0;
    endtask

    task automatic pulse_init();
        @(negedge CLK_40);
        init = 1'b1;
        @(negedge CLK_40);
        init = 1'b0;
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_nv"}, vid.size(), expv.size());
        foreach (expv[i]) check({tag, "_v"}, (i < vid.size()) ? vid[i] : 8'hxx, expv[i]);
        check({tag, "_na"}, aud.size(), expa.size());
        foreach (expa[i]) check({tag, "_a"}, (i < aud.size()) ? aud[i] : 8'hxx, expa[i]);
    endtask

    task automatic wait_frame(input string tag);
        for (int i = 0; i < 2000 && n_frame == 0; i++) @(negedge CLK_40);
        check({tag, "_frame_seen"}, n_frame, 1);
    endtask

    task automatic stop_to_idle(input string tag);
        @(negedge CLK_40);
        stop = 1'b1;
        for (int i = 0; i < 500 && busy; i++) @(negedge CLK_40);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_cs"}, chip_select, 1);
        stop = 1'b0;
    endtask

    initial begin
        int n_hi;
        #1;
        check("rst_spi_clk", SPI_clk, 0);
        check("rst_mosi", MOSI, 1);
        check("rst_cs", chip_select, 1);
        check("rst_data", data, 0);
        check("rst_strobes", {write_video, write_audio, frame_done}, 0);
        check("rst_flags", {hdr_timeout, busy}, 0);
        repeat (3) @(negedge CLK_40);
        reset = 1'b0;

        // basic frame
        stream = '{8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A};
        expv = '{8'h11, 8'h22, 8'h33, 8'h44};
        expa = '{8'hA5, 8'h5A};
        load(0);
        clear_mon();
        pulse_init();
        check("init_busy", busy, 1);
        check("init_cs", chip_select, 0);
        wait_frame("basic");
        repeat (2) @(negedge CLK_40);
        check_bytes("basic");
        check("basic_whdr_busy", busy, 1);
        check("basic_whdr_cs", chip_select, 0);
        stop_to_idle("basic");

        // video buffer stall on byte 2
        load(0);
        clear_mon();
        pulse_init();
        for (int i = 0; i < 1000 && vid.size() < 1; i++) @(negedge CLK_40);
        video_ready = 1'b0;
        repeat (40) @(negedge CLK_40);
        n_hi = 0;
        repeat (50) begin
            @(negedge CLK_40);
            if (SPI_clk) n_hi++;
        end
        check("stall_clk_high", n_hi, 0);
        check("stall_nwrites", vid.size(), 1);
        check("stall_data", data, 8'h22);
        video_ready = 1'b1;
        @(negedge CLK_40);
        check("stall_release_wr", write_video, 1);
        wait_frame("stall");
        check_bytes("stall");
        stop_to_idle("stall");

        // header 3 bits off byte alignment, payload containing header pattern
        stream = '{8'h00, 8'hFF, 8'hFF, 8'h0F, 8'hF0, 8'h3C, 8'h81, 8'h7E};
        expv = '{8'hFF, 8'h0F, 8'hF0, 8'h3C};
        expa = '{8'h81, 8'h7E};
        load(3);
        clear_mon();
        pulse_init();
        wait_frame("align");
        check_bytes("align");
        stop_to_idle("align");

        // header timeout with MISO stuck low
        bits.delete();
        MISO = 1'b0;
        clear_mon();
        pulse_init();
        n_rise = 0;
        for (int i = 0; i < 2000 && !hdr_timeout; i++) @(negedge CLK_40);
        check("tmo_flag", hdr_timeout, 1);
        check("tmo_cs", chip_select, 1);
        check("tmo_rises", n_rise, 100);
        repeat (5) @(negedge CLK_40);
        check("tmo_sticky", hdr_timeout, 1);

        // init together with stop stays idle
        @(negedge CLK_40);
        stop = 1'b1;
        init = 1'b1;
        @(negedge CLK_40);
        init = 1'b0;
        stop = 1'b0;
        @(negedge CLK_40);
        check("initstop_busy", busy, 0);
        check("initstop_tmo_kept", hdr_timeout, 1);

        // reset during third video byte, then clean restart
        stream = '{8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A};
        expv = '{8'h11, 8'h22, 8'h33, 8'h44};
        expa = '{8'hA5, 8'h5A};
        load(0);
        clear_mon();
        pulse_init();
        check("init_clears_tmo", hdr_timeout, 0);
        for (int i = 0; i < 1000 && vid.size() < 2; i++) @(negedge CLK_40);
        repeat (10) @(negedge CLK_40);
        #3 reset = 1'b1;
        #1;
        check("arst_spi_clk", SPI_clk, 0);
        check("arst_cs", chip_select, 1);
        check("arst_data", data, 0);
        check("arst_flags", {write_video, write_audio, frame_done, hdr_timeout, busy}, 0);
        repeat (2) @(negedge CLK_40);
        reset = 1'b0;
        @(negedge CLK_40);
        check("arst_no_strobe", {write_video, write_audio}, 0);
        load(0);
        clear_mon();
        pulse_init();
        wait_frame("restart");
        check_bytes("restart");
        stop_to_idle("restart");

        // stop during first audio byte
        load(0);
        clear_mon();
        pulse_init();
        for (int i = 0; i < 1000 && vid.size() < 4; i++) @(negedge CLK_40);
        stop = 1'b1;
        for (int i = 0; i < 500 && busy; i++) @(negedge CLK_40);
        stop = 1'b0;
        repeat (20) @(negedge CLK_40);
        check("stop_naud", aud.size(), 1);
        check("stop_aud0", (aud.size() > 0) ? aud[0] : 8'hxx, 8'hA5);
        check("stop_no_frame", n_frame, 0);
        check("stop_busy", busy, 0);
        check("stop_cs", chip_select, 1);

        check("strobes_exclusive", n_both, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_frame_sequencer.md
SPI_FRAME_SEQUENCER -- requirements
Module: spi_frame_sequencer

Interface
REQ-001 Parameter SPI_DIV, default 20, CLK_40 cycles per SPI_clk half-period (1 MHz SPI_clk).
REQ-002 Parameter VIDEO_BYTES, default 4800, video payload bytes per frame.
REQ-003 Parameter AUDIO_BYTES, default 735, audio payload bytes per frame.
REQ-004 Parameter HDR_BYTE, default 8'hFF, frame header pattern.
REQ-005 Parameter HDR_TIMEOUT, default 65535, max SPI bits spent in WAIT_HDR before timeout.
REQ-006 CLK_40  in  1  system clock, 40 MHz; only clock; all logic on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 init  in  1  start pulse; begins streaming from IDLE.
REQ-009 stop  in  1  level; return to IDLE at next byte boundary.
REQ-010 MISO  in  1  serial data from card.
REQ-011 video_ready, audio_ready  in  1 each  downstream buffer can accept a byte.
REQ-012 SPI_clk  out  1  generated SPI clock, idle low (mode 0).
REQ-013 MOSI  out  1  held 1 at all times (read-only stream).
REQ-014 chip_select  out  1  active-low card select.
REQ-015 data  out  8  received byte, valid with write strobes.
REQ-016 write_video, write_audio  out  1 each  single-cycle byte write strobes.
REQ-017 frame_done  out  1  single-cycle pulse after last audio byte written.
REQ-018 hdr_timeout  out  1  sticky error flag; busy  out  1  high when not IDLE.

Function
REQ-019 States IDLE, WAIT_HDR, VIDEO, AUDIO; init in IDLE -> WAIT_HDR next cycle; init ignored elsewhere.
REQ-020 chip_select = 0 in every state but IDLE; SPI_clk low and divider cleared in IDLE.
REQ-021 Divider counts 0..SPI_DIV-1 and toggles SPI_clk on terminal count; counter frozen while stalled.
REQ-022 MISO shifted MSB-first into shift register on the CLK_40 edge where SPI_clk goes 0->1.
REQ-023 WAIT_HDR: header match on shift register == HDR_BYTE checked every bit (bit-aligned); match -> VIDEO with bit count cleared; payload bytes not searched for header.
REQ-024 VIDEO/AUDIO: after 8th rising SPI_clk of a byte, data latched and matching strobe asserted on the next CLK_40 cycle if ready is high.
REQ-025 Stall: ready low at byte completion -> SPI_clk held low, byte held in data, strobe asserted in the cycle after ready rises; no bit lost or duplicated.
REQ-026 Byte counter 16-bit; VIDEO -> AUDIO after write of byte VIDEO_BYTES-1; AUDIO -> WAIT_HDR after byte AUDIO_BYTES-1, with frame_done in same cycle as final write_audio.
REQ-027 write_video and write_audio never high in the same cycle; ready ignored outside its own state.
REQ-028 stop high: finish current byte (including stall), then IDLE; in WAIT_HDR go IDLE at next SPI_clk falling edge.
REQ-029 WAIT_HDR bit count reaching HDR_TIMEOUT -> hdr_timeout = 1, state IDLE; flag cleared only by reset or next init.
REQ-030 init and stop both high in IDLE: stop wins, stay IDLE.

Reset
REQ-031 reset asserted: state IDLE, SPI_clk 0, MOSI 1, chip_select 1, data 8'h00, all strobes, frame_done, hdr_timeout, busy 0, all counters 0, immediately without a clock edge.
REQ-032 reset mid-frame discards the partial byte and the byte count; no strobe in the cycle after reset release.

Verification
REQ-033 Params VIDEO_BYTES=4, AUDIO_BYTES=2; init, MISO stream FF,11,22,33,44,A5,5A -> write_video data 11,22,33,44 then write_audio A5,5A, one frame_done, back to WAIT_HDR.
REQ-034 video_ready low for 50 cycles at byte 2 -> SPI_clk frozen low, write_video for 22 only after ready rises, next bytes intact.
REQ-035 Bitstream 0,FF shifted by 3 bits -> header found bit-aligned; first video byte is the 8 bits after header.
REQ-036 MISO held 0, HDR_TIMEOUT=100 -> hdr_timeout=1 and chip_select=1 after 100 SPI_clk rising edges.
REQ-037 reset pulse during 3rd video byte -> all outputs at reset values asynchronously; next init restarts header search cleanly.
REQ-038 stop asserted mid-byte 1 of audio -> that byte written, then IDLE, chip_select=1, busy=0.
